uart_bus_arbiter: RTL and testbench

- Two-requester arbiter for the memory-mapped UART peripheral bus, which carries valid/instr/addr/wdata/wstrb/rdata/ready.
- Sits between the requesters and the single uart slave. Requester 0 is the core data port; requester 1 is the debug/loader port.
- Grants are round-robin and held until the slave completes the transaction. A watchdog terminates transactions the slave never completes.

---
 rtl/uart_bus_arbiter_if.sv | 12 +
 rtl/uart_bus_arbiter.sv | 66 ++++++
 tb/tb_uart_bus_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_bus_arbiter_if.sv
// uart_bus_arbiter_if: memory-mapped UART bus request/response bundle.
interface uart_bus_arbiter_if;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    modport master (output valid, instr, addr, wdata, wstrb, input rdata, ready);
    modport slave (input valid, instr, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/uart_bus_arbiter.sv
// uart_bus_arbiter: two-requester round-robin arbiter in front of the uart slave,
// holding each grant until completion, with a watchdog that forces error completions.
module uart_bus_arbiter #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 11
) (
    input  logic                       clock,
    input  logic                       reset,
    uart_bus_arbiter_if.slave          m0,
    uart_bus_arbiter_if.slave          m1,
    uart_bus_arbiter_if.master         s,
    output logic                       timeout_err
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
    state_t           state_q, state_d;
    logic             owner_q, owner_d, prio_q, prio_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy, own_valid, expire, done;
    always_comb begin
        busy      = state_q == BUSY;
        own_valid = owner_q ? m1.valid : m0.valid;
        expire    = busy && (TIMEOUT != 0) && !s.ready && cnt_q == LAST;
        done      = busy && (s.ready || expire);
        state_d   = state_q;
        owner_d   = owner_q;
        prio_d    = prio_q;
        cnt_d     = cnt_q;
        if (!busy) begin
            if (m0.valid || m1.valid) begin
                state_d = BUSY;
                owner_d = (m0.valid && m1.valid) ? prio_q : m1.valid;
            end
        end else if (done) begin
            state_d = IDLE;
            prio_d  = ~owner_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end
    // Request fields are muxed straight through; only s_valid is cut on a forced completion.
    assign s.valid     = busy && own_valid && !expire;
    assign s.instr     = busy && (owner_q ? m1.instr : m0.instr);
    assign s.addr      = !busy ? '0 : owner_q ? m1.addr : m0.addr;
    assign s.wdata     = !busy ? '0 : owner_q ? m1.wdata : m0.wdata;
    assign s.wstrb     = !busy ? '0 : owner_q ? m1.wstrb : m0.wstrb;
    assign m0.ready    = done && !owner_q;
    assign m1.ready    = done && owner_q;
    assign m0.rdata    = (done && !owner_q && !expire) ? s.rdata : '0;
    assign m1.rdata    = (done && owner_q && !expire) ? s.rdata : '0;
    assign timeout_err = expire;
endmodule

// File: tb/tb_uart_bus_arbiter.sv
// tb_uart_bus_arbiter: directed vector table plus hand sequences for uart_bus_arbiter.
module tb_uart_bus_arbiter;
    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0004;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic timeout_err;
    int   total = 0;
    int   bad = 0;
    uart_bus_arbiter_if m0_b ();
    uart_bus_arbiter_if m1_b ();
    uart_bus_arbiter_if s_b ();
    uart_bus_arbiter #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .m0(m0_b), .m1(m1_b), .s(s_b), .timeout_err(timeout_err)
    );
    always #5 clock = ~clock;
    typedef struct {
        logic        rs, v0, v1, sr;
        logic [3:0]  ws0;
        logic [31:0] srd;
        logic [103:0] exp;
    } vec_t;
    vec_t tv[64];
    int   n = 0;
    task automatic t(input int rs, v0, v1, ws0, sr, srd, sv, sa, sw, r0, rd0, r1, rd1, te);
        tv[n].rs  = rs != 0;
        tv[n].v0  = v0 != 0;
        tv[n].v1  = v1 != 0;
        tv[n].ws0 = 4'(ws0);
        tv[n].sr  = sr != 0;
        tv[n].srd = srd;
        tv[n].exp = {sv != 0, 32'(sa), 4'(sw), r0 != 0, 32'(rd0), r1 != 0, 32'(rd1), te != 0};
        n++;
    endtask
    task automatic z(input int rs, v0, v1, ws0, sr, srd);
        t(rs, v0, v1, ws0, sr, srd, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [103:0] outs();
        return {s_b.valid, s_b.addr, s_b.wstrb, m0_b.ready, m0_b.rdata, m1_b.ready, m1_b.rdata, timeout_err};
    endfunction
    task automatic step();
        @(posedge clock);
        #1;
    endtask
    initial begin
        int k;
        bit got;
        logic te;
        m0_b.valid = 0; m0_b.instr = 0; m0_b.addr = A0; m0_b.wdata = 32'h41; m0_b.wstrb = 0;
        m1_b.valid = 0; m1_b.instr = 1; m1_b.addr = A1; m1_b.wdata = 32'h1234; m1_b.wstrb = 0;
        s_b.ready = 0; s_b.rdata = 0;
        // single m0 read, stray s_ready in IDLE
        z(1, 0, 0, 0, 0, 0);
        z(0, 1, 0, 0, 0, 0);
        t(0, 1, 0, 0, 0, 0, 1, A0, 0, 0, 0, 0, 0, 0);
        t(0, 1, 0, 0, 0, 0, 1, A0, 0, 0, 0, 0, 0, 0);
        t(0, 1, 0, 0, 1, 'hA5, 1, A0, 0, 1, 'hA5, 0, 0, 0);
        z(0, 0, 0, 0, 0, 0);
        z(0, 0, 0, 0, 1, 'h77);
        // simultaneous requests from reset, then continuous alternation
        z(1, 0, 0, 0, 0, 0);
        z(0, 1, 1, 1, 0, 0);
        t(0, 1, 1, 1, 0, 0, 1, A0, 1, 0, 0, 0, 0, 0);
        t(0, 1, 1, 1, 1, 0, 1, A0, 1, 1, 0, 0, 0, 0);
        z(0, 1, 1, 1, 0, 0);
        t(0, 1, 1, 1, 0, 0, 1, A1, 0, 0, 0, 0, 0, 0);
        t(0, 1, 1, 1, 1, 'hB6, 1, A1, 0, 0, 0, 1, 'hB6, 0);
        z(0, 1, 1, 1, 0, 0);
        t(0, 1, 1, 1, 1, 'hC7, 1, A0, 1, 1, 'hC7, 0, 0, 0);
        z(0, 1, 1, 1, 0, 0);
        t(0, 1, 1, 1, 1, 'h0D, 1, A1, 0, 0, 0, 1, 'h0D, 0);
        // fairness: m1 arrives mid m0 transaction
        z(0, 1, 0, 0, 0, 0);
        t(0, 1, 0, 0, 0, 0, 1, A0, 0, 0, 0, 0, 0, 0);
        t(0, 1, 1, 0, 0, 0, 1, A0, 0, 0, 0, 0, 0, 0);
        t(0, 1, 1, 0, 1, 'h11, 1, A0, 0, 1, 'h11, 0, 0, 0);
        z(0, 1, 1, 0, 0, 0);
        t(0, 1, 1, 0, 1, 'h22, 1, A1, 0, 0, 0, 1, 'h22, 0);
        // watchdog expiry on the 8th BUSY cycle
        z(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) t(0, 1, 0, 0, 0, 'hEE, 1, A0, 0, 0, 0, 0, 0, 0);
        t(0, 1, 0, 0, 0, 'hEE, 0, A0, 0, 1, 0, 0, 0, 1);
        // s_ready on the expiry cycle wins
        z(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) t(0, 1, 0, 0, 0, 0, 1, A0, 0, 0, 0, 0, 0, 0);
        t(0, 1, 0, 0, 1, 'h5A, 1, A0, 0, 1, 'h5A, 0, 0, 0);
        z(0, 0, 0, 0, 0, 0);
        // reset mid-BUSY on an m1 transaction, then a clean m1 transaction
        z(0, 0, 1, 0, 0, 0);
        t(0, 0, 1, 0, 0, 0, 1, A1, 0, 0, 0, 0, 0, 0);
        z(1, 0, 1, 0, 1, 'h99);
        z(0, 0, 1, 0, 0, 0);
        t(0, 0, 1, 0, 1, 'h3C, 1, A1, 0, 0, 0, 1, 'h3C, 0);
        z(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) begin
            reset = tv[i].rs;
            m0_b.valid = tv[i].v0;
            m0_b.wstrb = tv[i].ws0;
            m1_b.valid = tv[i].v1;
            s_b.ready = tv[i].sr;
            s_b.rdata = tv[i].srd;
            @(negedge clock);
            chk($sformatf("vec%0d", i), outs(), tv[i].exp);
            step();
        end
        // hand sequence: watchdog latency measured with a bounded wait
        m0_b.valid = 1; s_b.ready = 0; s_b.rdata = 32'hDEAD;
        got = 0; k = -1; te = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            if (m0_b.ready) begin got = 1; k = i; te = timeout_err; end
            step();
        end
        chk("wd_latency", 104'(k), 104'(8));
        chk("wd_err", {103'(0), te}, 104'(1));
        m0_b.valid = 0;
        step();
        // hand sequence: m1 grant latency and field forwarding with a 3-cycle slave
        m1_b.valid = 1;
        got = 0; k = -1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clock);
            if (s_b.valid) begin got = 1; k = i; end
            step();
        end
        chk("grant_latency", 104'(k), 104'(1));
        step();
        s_b.ready = 1; s_b.rdata = 32'h5EED;
        @(negedge clock);
        chk("m1_fwd", {30'(0), m1_b.ready, s_b.instr, m1_b.rdata, s_b.wdata, s_b.addr, m0_b.ready, 1'b0},
            {30'(0), 1'b1, 1'b1, 32'h5EED, 32'h1234, A1, 1'b0, 1'b0});
        step();
        s_b.ready = 0; m1_b.valid = 0;
        @(negedge clock);
        chk("post_idle", outs(), 104'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
